// File: rtl/mem_fill_pkg.sv
// rtl/mem_fill_pkg.sv - shared state encoding and default geometry for the line-fill responder
package mem_fill_pkg;

    localparam int DEF_WORDS_PER_LINE = 8;
    localparam int DEF_ADDR_W         = 32;
    localparam int DEF_DATA_W         = 32;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WB_WRITE = 3'd1,
        RD_ISSUE = 3'd2,
        RD_WAIT  = 3'd3,
        DONE     = 3'd4
    } fill_state_t;

endpackage

// File: rtl/fill_beat_counter.sv
// rtl/fill_beat_counter.sv - word-within-line beat counter with clear, increment and last flag
module fill_beat_counter #(
    parameter int WORDS_PER_LINE = 8
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              clr,
    input  logic                              inc,
    output logic [$clog2(WORDS_PER_LINE)-1:0] beat,
    output logic                              last
);

    localparam int IDX_W = $clog2(WORDS_PER_LINE);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            beat <= '0;
        end else if (clr) begin
            beat <= '0;
        end else if (inc) begin
            beat <= beat + 1'b1;
        end
    end

    assign last = (beat == IDX_W'(WORDS_PER_LINE - 1));

endmodule

// File: rtl/mem_fill_responder.sv
// rtl/mem_fill_responder.sv - cache line fill FSM, one read outstanding; FILL_WRITEBACK_EN adds victim write-back
module mem_fill_responder
    import mem_fill_pkg::*;
#(
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              req_valid,
    input  logic [ADDR_W-1:0]                 req_addr,
    output logic                              req_ready,
    input  logic                              req_wb,
    input  logic [ADDR_W-1:0]                 req_wb_addr,
    output logic [$clog2(WORDS_PER_LINE)-1:0] wb_idx,
    input  logic [DATA_W-1:0]                 wb_data,
    output logic [ADDR_W-1:0]                 mem_addr,
    output logic                              mem_rd,
    output logic                              mem_we,
    output logic [DATA_W-1:0]                 mem_wdata,
    input  logic [DATA_W-1:0]                 mem_rdata,
    input  logic                              mem_rvalid,
    output logic                              fill_valid,
    output logic [DATA_W-1:0]                 fill_data,
    output logic [$clog2(WORDS_PER_LINE)-1:0] fill_idx,
    output logic                              fill_done,
    output logic                              busy
);

    localparam int IDX_W = $clog2(WORDS_PER_LINE);
    localparam int OFF_W = IDX_W + 2;
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(WORDS_PER_LINE * 4 - 1);

    fill_state_t        state, state_nx;
    logic [ADDR_W-1:0]  line_base;
    logic [ADDR_W-1:0]  word_off;
    logic [IDX_W-1:0]   beat;
    logic               beat_last;
    logic               beat_clr;
    logic               beat_inc;
    logic               accept;

    assign accept   = (state == IDLE) && req_valid;
    assign word_off = {{(ADDR_W - OFF_W){1'b0}}, beat, 2'b00};

    fill_beat_counter #(
        .WORDS_PER_LINE(WORDS_PER_LINE)
    ) u_beat (
        .CLK  (CLK),
        .RST  (RST),
        .clr  (beat_clr),
        .inc  (beat_inc),
        .beat (beat),
        .last (beat_last)
    );

`ifdef FILL_WRITEBACK_EN
    logic [ADDR_W-1:0] vic_base;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            vic_base <= '0;
        end else if (accept && req_wb) begin
            vic_base <= req_wb_addr & LINE_MASK;
        end
    end
`else
    logic unused_wb;
    assign unused_wb = ^{req_wb, req_wb_addr, wb_data};
`endif

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state     <= IDLE;
            line_base <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                line_base <= req_addr & LINE_MASK;
            end
        end
    end

    always_comb begin
        state_nx   = state;
        beat_clr   = 1'b0;
        beat_inc   = 1'b0;
        req_ready  = 1'b0;
        busy       = 1'b1;
        mem_rd     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        wb_idx     = '0;
        fill_valid = 1'b0;
        fill_data  = '0;
        fill_idx   = '0;
        fill_done  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    beat_clr = 1'b1;
                    state_nx = RD_ISSUE;
`ifdef FILL_WRITEBACK_EN
                    if (req_wb) begin
                        state_nx = WB_WRITE;
                    end
`endif
                end
            end
`ifdef FILL_WRITEBACK_EN
            WB_WRITE: begin
                mem_we    = 1'b1;
                mem_addr  = vic_base + word_off;
                wb_idx    = beat;
                mem_wdata = wb_data;
                if (beat_last) begin
                    beat_clr = 1'b1;
                    state_nx = RD_ISSUE;
                end else begin
                    beat_inc = 1'b1;
                end
            end
`endif
            RD_ISSUE: begin
                mem_rd   = 1'b1;
                mem_addr = line_base + word_off;
                state_nx = RD_WAIT;
            end
            RD_WAIT: begin
                // Response is forwarded in the same cycle it arrives; nothing is buffered.
                if (mem_rvalid) begin
                    fill_valid = 1'b1;
                    fill_data  = mem_rdata;
                    fill_idx   = beat;
                    if (beat_last) begin
                        beat_clr = 1'b1;
                        state_nx = DONE;
                    end else begin
                        beat_inc = 1'b1;
                        state_nx = RD_ISSUE;
                    end
                end
            end
            DONE: begin
                fill_done = 1'b1;
                state_nx  = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_fill_responder.sv
// tb/tb_mem_fill_responder.sv - scoreboard bench for mem_fill_responder; FILL_WRITEBACK_EN enables the write-back case
module tb_mem_fill_responder;

    localparam int W  = 8;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 3;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          req_valid = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic          req_ready;
    logic          req_wb = 1'b0;
    logic [AW-1:0] req_wb_addr = '0;
    logic [IW-1:0] wb_idx;
    logic [DW-1:0] wb_data;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_rvalid = 1'b0;
    logic          fill_valid;
    logic [DW-1:0] fill_data;
    logic [IW-1:0] fill_idx;
    logic          fill_done;
    logic          busy;

    always #5 CLK = ~CLK;

    mem_fill_responder #(.WORDS_PER_LINE(W), .ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .req_wb(req_wb), .req_wb_addr(req_wb_addr), .wb_idx(wb_idx), .wb_data(wb_data),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .fill_valid(fill_valid), .fill_data(fill_data), .fill_idx(fill_idx),
        .fill_done(fill_done), .busy(busy)
    );

    // Victim cache line contents as seen by the responder.
    assign wb_data = 32'hB0B0_0000 | 32'(wb_idx);

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_func(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    logic [31:0] exp_rd_q[$];
    logic [63:0] exp_fill_q[$];
    logic [63:0] exp_wr_q[$];
    int  exp_done = 0;
    int  fills_seen = 0;
    int  dones_seen = 0;
    int  done_cyc = 0;
    int  cyc = 0;
    bit  outstanding = 0;
    bit  ready_chk = 0;

    always @(posedge CLK) cyc++;

    // Memory model: one response per read, latency chosen per read.
    int  lat_fixed = 1;
    int  slow_beat = -1;
    int  slow_lat = 5;
    bit  stray_en = 0;

    initial begin
        bit          rd_now, pend, prev_drove;
        logic [31:0] addr_now, pa;
        int          cnt, lat;
        pend = 0;
        prev_drove = 0;
        cnt = 0;
        pa = '0;
        forever begin
            @(negedge CLK);
            rd_now   = mem_rd;
            addr_now = mem_addr;
            @(posedge CLK);
            #1;
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            if (stray_en && prev_drove) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 32'hDEAD_BEEF;
            end
            prev_drove = 0;
            if (rd_now) begin
                if (((addr_now % (W * 4)) / 4) == slow_beat) lat = slow_lat;
                else if (lat_fixed > 0) lat = lat_fixed;
                else lat = $urandom_range(1, 4);
                pend = 1;
                cnt  = lat;
                pa   = addr_now;
            end
            if (pend) begin
                if (cnt == 1) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = mem_func(pa);
                    pend       = 0;
                    prev_drove = 1;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Monitor: every DUT output event is matched against the scoreboard.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge CLK);
            if (ready_chk) begin
                chk("ready_after_done", {62'd0, req_ready, busy}, 64'd2);
                ready_chk = 0;
            end
            if (mem_we) begin
                if (exp_wr_q.size() == 0) chk("wr_unexpected", mem_addr, 64'hFFFF_FFFF_FFFF_FFFF);
                else begin
                    e = exp_wr_q.pop_front();
                    chk("wr_beat", {mem_addr, mem_wdata}, e);
                end
            end
            if (mem_rd) begin
                chk("rd_before_wb_done", exp_wr_q.size(), 0);
                chk("one_outstanding", outstanding, 0);
                outstanding = 1;
                if (exp_rd_q.size() == 0) chk("rd_unexpected", mem_addr, 64'hFFFF_FFFF_FFFF_FFFF);
                else chk("rd_addr", mem_addr, exp_rd_q.pop_front());
            end
            if (fill_valid) begin
                outstanding = 0;
                fills_seen++;
                if (exp_fill_q.size() == 0) chk("fill_unexpected", fill_idx, 64'hFFFF_FFFF_FFFF_FFFF);
                else begin
                    e = exp_fill_q.pop_front();
                    chk("fill_beat", {32'(fill_idx), fill_data}, e);
                end
            end
            if (fill_done) begin
                chk("done_expected", exp_done > 0, 1);
                if (exp_done > 0) exp_done--;
                dones_seen++;
                done_cyc = cyc;
                ready_chk = 1;
            end
        end
    end

    int req_cyc = 0;

    task automatic start_fill(input logic [31:0] addr, input bit wb, input logic [31:0] wb_addr);
        int n;
        logic [31:0] base, vbase;
        n = 0;
        while (!req_ready && n < 200) begin
            @(posedge CLK); #1; n++;
        end
        chk("ready_timeout", n < 200, 1);
        base  = addr - (addr % (W * 4));
        vbase = wb_addr - (wb_addr % (W * 4));
        for (int i = 0; i < W; i++) begin
            if (wb) exp_wr_q.push_back({vbase + 32'(4 * i), 32'hB0B0_0000 | 32'(i)});
            exp_rd_q.push_back(base + 32'(4 * i));
            exp_fill_q.push_back({32'(i), mem_func(base + 32'(4 * i))});
        end
        exp_done++;
        req_valid   = 1'b1;
        req_addr    = addr;
        req_wb      = wb;
        req_wb_addr = wb_addr;
        req_cyc     = cyc;
        @(posedge CLK); #1;
        req_valid = 1'b0;
        req_wb    = 1'b0;
        req_addr  = $urandom;
    endtask

    task automatic wait_done(input int d0, output int lat_incl);
        int n;
        n = 0;
        while (dones_seen == d0 && n < 400) begin
            @(posedge CLK); #1; n++;
        end
        chk("done_timeout", dones_seen > d0, 1);
        lat_incl = done_cyc - req_cyc + 1;
    endtask

    task automatic do_fill(input logic [31:0] addr, input bit wb, input logic [31:0] wb_addr,
                           input bit pulse, output int lat_incl);
        int d0;
        d0 = dones_seen;
        start_fill(addr, wb, wb_addr);
        if (pulse) begin
            req_valid = 1'b1; req_addr = $urandom;
            @(posedge CLK); #1;
            req_valid = 1'b0;
            @(posedge CLK); #1;
            req_valid = 1'b1; req_addr = $urandom;
            @(posedge CLK); #1;
            req_valid = 1'b0;
        end
        wait_done(d0, lat_incl);
        @(posedge CLK); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, f0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_fill_valid", fill_valid, 0);
        chk("rst_fill_done", fill_done, 0);
        chk("rst_mem_addr", mem_addr, 0);
        RST = 1'b1;
        @(posedge CLK); #1;

        // Back-to-back 1-cycle responses: 2 + W + sum(latencies) cycles inclusive.
        lat_fixed = 1;
        do_fill(32'h0000_1234, 0, 0, 0, lat);
        chk("lat_basic", lat, 2 + W + W);

        slow_beat = 3; slow_lat = 5;
        do_fill(32'h0000_5678, 0, 0, 0, lat);
        chk("lat_slow_beat3", lat, 2 + W + (W - 1) + 5);
        slow_beat = -1;

        stray_en = 1;
        f0 = fills_seen;
        do_fill(32'h0000_9AB0, 0, 0, 1, lat);
        chk("stray_fill_count", fills_seen - f0, W);
        chk("lat_stray", lat, 2 + W + W);
        stray_en = 0;

        // Reset in the middle of a fill with a response still in flight.
        lat_fixed = 5;
        f0 = fills_seen;
        start_fill(32'h0000_7777, 0, 0);
        begin
            int n;
            n = 0;
            while (fills_seen - f0 < 4 && n < 200) begin
                @(posedge CLK); #1; n++;
            end
            chk("midfill_progress", fills_seen - f0 >= 4, 1);
        end
        RST = 1'b0;
        @(posedge CLK); #1;
        exp_rd_q.delete();
        exp_fill_q.delete();
        exp_wr_q.delete();
        exp_done = 0;
        outstanding = 0;
        chk("midrst_req_ready", req_ready, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_fill_done", fill_done, 0);
        chk("midrst_mem_rd", mem_rd, 0);
        RST = 1'b1;
        repeat (10) @(posedge CLK);
        #1;
        lat_fixed = 1;
        do_fill(32'h0000_2000, 0, 0, 0, lat);
        chk("lat_after_reset", lat, 2 + W + W);

        lat_fixed = 0;
        for (int t = 0; t < 6; t++) begin
            stray_en = $urandom_range(0, 1);
            do_fill($urandom, 0, 0, $urandom_range(0, 1), lat);
            chk("lat_random_min", lat >= 2 * W + 2, 1);
        end
        stray_en = 0;

        lat_fixed = 1;
        do_fill(32'hFFFF_FFFC, 0, 0, 0, lat);
        chk("lat_top_of_space", lat, 2 + W + W);

`ifdef FILL_WRITEBACK_EN
        do_fill(32'h0000_4000, 1, 32'h0000_3010, 0, lat);
        chk("lat_writeback", lat, 2 + W + W + W);
`endif

        repeat (3) @(posedge CLK);
        #1;
        chk("left_reads", exp_rd_q.size(), 0);
        chk("left_fills", exp_fill_q.size(), 0);
        chk("left_writes", exp_wr_q.size(), 0);
        chk("left_dones", exp_done, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
